// File: rtl/led_frame_decoder_if.sv
// Serial LED-frame input stream and decoded result handshake, bundled for led_frame_decoder.
interface led_frame_decoder_if;
  logic        s_data;
  logic        s_valid;
  logic        sof;
  logic        frame_ready;
  logic [15:0] gameboard;
  logic [15:0] player_moves;
  logic [4:0]  piece_count;
  logic        err_illegal;
  logic        err_gravity;
  logic        out_valid;
  logic        out_ready;

  // Producer of the serial stream and consumer of the decoded board
  modport master (
    output s_data, s_valid, sof, out_ready,
    input  frame_ready, gameboard, player_moves, piece_count, err_illegal, err_gravity,
           out_valid
  );

  // The decoder itself
  modport slave (
    input  s_data, s_valid, sof, out_ready,
    output frame_ready, gameboard, player_moves, piece_count, err_illegal, err_gravity,
           out_valid
  );
endinterface

// File: rtl/led_frame_decoder.sv
// Deserialises a 32-bit LED frame (bit 0 first) into a 4x4 board: occupancy, owner,
// piece count and error flags, presented with a valid/ready handshake.
// Optional macro LED_GRAVITY_CHECK_EN enables the gravity (floating piece) check;
// when undefined err_gravity is tied to 0.
module led_frame_decoder (
  input logic           clk,
  input logic           reset,
  led_frame_decoder_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StShift, StDecode, StHold} state_e;

  state_e      state;
  logic [31:0] shift_reg;
  logic [4:0]  bit_count;
  logic [15:0] gameboard;
  logic [15:0] player_moves;
  logic [4:0]  piece_count;
  logic        err_illegal;
  logic        err_gravity;
  logic        out_valid;

  logic        frame_ready;
  logic        accept;
  logic [15:0] gb_dec;
  logic [15:0] pm_dec;
  logic [4:0]  pc_dec;
  logic        ill_dec;
  logic        grav_dec;

  // Reset gates frame_ready so it reads 0 for the whole time reset is held
  assign frame_ready = reset & ((state == StIdle) | (state == StShift));
  assign accept      = bus.s_valid & frame_ready;

  // Pair decode of the captured frame; an illegal 11 pair counts as empty
  always_comb begin
    gb_dec  = '0;
    pm_dec  = '0;
    pc_dec  = '0;
    ill_dec = 1'b0;
    for (int i = 0; i < 16; i++) begin
      case (shift_reg[2*i+1 -: 2])
        2'b01:   gb_dec[i] = 1'b1;
        2'b10: begin
          gb_dec[i] = 1'b1;
          pm_dec[i] = 1'b1;
        end
        2'b11:   ill_dec = 1'b1;
        default: ;
      endcase
      pc_dec = pc_dec + 5'(gb_dec[i]);
    end
  end

`ifdef LED_GRAVITY_CHECK_EN
  // Flag any occupied cell sitting directly on an empty cell of the same column
  always_comb begin
    grav_dec = 1'b0;
    for (int c = 0; c < 4; c++) begin
      for (int k = 1; k < 4; k++) begin
        if (gb_dec[4*c+k] && !gb_dec[4*c+k-1]) grav_dec = 1'b1;
      end
    end
  end
`else
  assign grav_dec = 1'b0;
`endif

  // Frame FSM: collect bits, decode for one cycle, then hold results until taken
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= StIdle;
      shift_reg    <= '0;
      bit_count    <= '0;
      gameboard    <= '0;
      player_moves <= '0;
      piece_count  <= '0;
      err_illegal  <= 1'b0;
      err_gravity  <= 1'b0;
      out_valid    <= 1'b0;
    end else begin
      case (state)
        StIdle: begin
          if (accept && bus.sof) begin
            shift_reg <= {31'b0, bus.s_data};
            bit_count <= 5'd1;
            state     <= StShift;
          end
        end
        StShift: begin
          if (accept) begin
            if (bus.sof) begin
              // Restart: the sof bit becomes bit 0 of a fresh frame
              shift_reg <= {31'b0, bus.s_data};
              bit_count <= 5'd1;
            end else begin
              shift_reg[bit_count] <= bus.s_data;
              bit_count            <= bit_count + 5'd1;
              if (bit_count == 5'd31) state <= StDecode;
            end
          end
        end
        StDecode: begin
          gameboard    <= gb_dec;
          player_moves <= pm_dec;
          piece_count  <= pc_dec;
          err_illegal  <= ill_dec;
          err_gravity  <= grav_dec;
          out_valid    <= 1'b1;
          state        <= StHold;
        end
        StHold: begin
          if (bus.out_ready) begin
            out_valid <= 1'b0;
            state     <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign bus.frame_ready  = frame_ready;
  assign bus.gameboard    = gameboard;
  assign bus.player_moves = player_moves;
  assign bus.piece_count  = piece_count;
  assign bus.err_illegal  = err_illegal;
  assign bus.err_gravity  = err_gravity;
  assign bus.out_valid    = out_valid;

endmodule

// File: tb/tb_led_frame_decoder.sv
// Bench for led_frame_decoder: directed frames with literal expectations plus a randomized
// run, all checked every cycle against a queue-based reference model of the frame protocol.
module tb_led_frame_decoder;

  logic clk;
  logic reset;
  led_frame_decoder_if bus ();

  led_frame_decoder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit          m_in_reset;
  bit          m_decode;
  bit          m_hold;
  bit          m_bits[$];
  logic [31:0] m_frame;
  logic [15:0] e_gb;
  logic [15:0] e_pm;
  logic [4:0]  e_pc;
  logic        e_ill;
  logic        e_grav;
  int          ov_rises;
  logic        prev_ov;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Board rules applied directly to a 32-bit frame
  task automatic ref_decode(input logic [31:0] f);
    int v;
    e_gb = '0; e_pm = '0; e_pc = '0; e_ill = 1'b0; e_grav = 1'b0;
    for (int i = 0; i < 16; i++) begin
      v = int'((f >> (2 * i)) & 32'd3);
      if (v == 1) e_gb[i] = 1'b1;
      else if (v == 2) begin e_gb[i] = 1'b1; e_pm[i] = 1'b1; end
      else if (v == 3) e_ill = 1'b1;
    end
    for (int i = 0; i < 16; i++) if (e_gb[i]) e_pc = e_pc + 5'd1;
`ifdef LED_GRAVITY_CHECK_EN
    for (int c = 0; c < 4; c++)
      for (int k = 1; k < 4; k++)
        if (e_gb[4*c+k] && !e_gb[4*c+k-1]) e_grav = 1'b1;
`endif
  endtask

  task automatic model_reset();
    m_in_reset = 1'b1;
    m_decode = 1'b0; m_hold = 1'b0;
    m_bits.delete();
    e_gb = '0; e_pm = '0; e_pc = '0; e_ill = 1'b0; e_grav = 1'b0;
  endtask

  // Effect of the coming rising edge given the inputs currently driven
  task automatic model_step();
    if (m_in_reset) return;
    if (m_decode) begin
      ref_decode(m_frame);
      m_decode = 1'b0;
      m_hold = 1'b1;
    end else if (m_hold) begin
      if (bus.out_ready) m_hold = 1'b0;
    end else if (bus.s_valid) begin
      if (bus.sof) begin
        m_bits.delete();
        m_bits.push_back(bus.s_data);
      end else if (m_bits.size() > 0) begin
        m_bits.push_back(bus.s_data);
      end
      if (m_bits.size() == 32) begin
        m_frame = '0;
        foreach (m_bits[i]) m_frame[i] = m_bits[i];
        m_bits.delete();
        m_decode = 1'b1;
      end
    end
  endtask

  task automatic check_all();
    check("frame_ready", 32'(bus.frame_ready), 32'(!m_in_reset && !m_decode && !m_hold));
    check("out_valid", 32'(bus.out_valid), 32'(m_hold));
    check("gameboard", 32'(bus.gameboard), 32'(e_gb));
    check("player_moves", 32'(bus.player_moves), 32'(e_pm));
    check("piece_count", 32'(bus.piece_count), 32'(e_pc));
    check("err_illegal", 32'(bus.err_illegal), 32'(e_ill));
    check("err_gravity", 32'(bus.err_gravity), 32'(e_grav));
    if (bus.out_valid && !prev_ov) ov_rises++;
    prev_ov = bus.out_valid;
  endtask

  task automatic tick();
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic send_bits(input logic [31:0] f, input int n, input bit with_sof);
    for (int i = 0; i < n; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = f[i];
      bus.sof     = (i == 0) && with_sof;
      tick();
    end
    bus.s_valid = 1'b0;
    bus.sof     = 1'b0;
    bus.s_data  = 1'b0;
  endtask

  task automatic release_result();
    bus.out_ready = 1'b1;
    tick();
    check("released_out_valid", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    bus.s_data = 1'b0; bus.s_valid = 1'b0; bus.sof = 1'b0; bus.out_ready = 1'b0;
    prev_ov = 1'b0; ov_rises = 0;
    reset = 1'b0;
    model_reset();
    #3;
    check_all();
    check("reset_frame_ready", 32'(bus.frame_ready), 32'd0);
    tick();
    tick();
    reset = 1'b1;
    m_in_reset = 1'b0;
    #1;
    check("ready_after_release", 32'(bus.frame_ready), 32'd1);

    // Single player-0 piece at the bottom of column 0; out_valid two edges after bit 31
    send_bits(32'h0000_0001, 32, 1'b1);
    check("ov_one_edge_after", 32'(bus.out_valid), 32'd0);
    tick();
    check("ov_two_edges_after", 32'(bus.out_valid), 32'd1);
    check("f1_gameboard", 32'(bus.gameboard), 32'h0001);
    check("f1_moves", 32'(bus.player_moves), 32'h0000);
    check("f1_count", 32'(bus.piece_count), 32'd1);
    check("f1_illegal", 32'(bus.err_illegal), 32'd0);
    release_result();

    // Cell0 player-1, cell1 illegal pair
    send_bits(32'h0000_000E, 32, 1'b1);
    tick();
    check("fe_gameboard", 32'(bus.gameboard), 32'h0001);
    check("fe_moves", 32'(bus.player_moves), 32'h0001);
    check("fe_illegal", 32'(bus.err_illegal), 32'd1);
    check("fe_gravity", 32'(bus.err_gravity), 32'd0);
    release_result();

    // Floating piece in cell1
    send_bits(32'h0000_0004, 32, 1'b1);
    tick();
    check("f4_gameboard", 32'(bus.gameboard), 32'h0002);
`ifdef LED_GRAVITY_CHECK_EN
    check("f4_gravity", 32'(bus.err_gravity), 32'd1);
`else
    check("f4_gravity", 32'(bus.err_gravity), 32'd0);
`endif
    release_result();

    // Restart on sof at bit 10, then a full 0x55555555 frame
    ov_rises = 0;
    send_bits(32'hFFFF_FFFF, 10, 1'b1);
    send_bits(32'h5555_5555, 32, 1'b1);
    tick();
    check("f5_gameboard", 32'(bus.gameboard), 32'hFFFF);
    check("f5_moves", 32'(bus.player_moves), 32'h0000);
    check("f5_count", 32'(bus.piece_count), 32'd16);

    // Stall in HOLD with s_valid toggling
    bus.sof = 1'b1; bus.s_data = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.s_valid = i[0];
      tick();
    end
    bus.s_valid = 1'b0; bus.sof = 1'b0; bus.s_data = 1'b0;
    check("hold_gameboard", 32'(bus.gameboard), 32'hFFFF);
    check("hold_out_valid", 32'(bus.out_valid), 32'd1);
    check("hold_ready", 32'(bus.frame_ready), 32'd0);
    release_result();
    check("idle_ready", 32'(bus.frame_ready), 32'd1);
    check("single_out_valid", 32'(ov_rises), 32'd1);

    // Reset mid-frame after 20 bits
    ov_rises = 0;
    send_bits(32'hAAAA_AAAA, 20, 1'b1);
    reset = 1'b0;
    #1;
    model_reset();
    check_all();
    check("rst_gameboard", 32'(bus.gameboard), 32'h0000);
    check("rst_ready", 32'(bus.frame_ready), 32'd0);
    tick();
    tick();
    reset = 1'b1;
    m_in_reset = 1'b0;
    tick();
    check("rst_no_out_valid", 32'(ov_rises), 32'd0);
    send_bits(32'h0000_0009, 32, 1'b1);
    tick();
    check("post_rst_gameboard", 32'(bus.gameboard), 32'h0003);
    check("post_rst_moves", 32'(bus.player_moves), 32'h0002);
    release_result();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bus.s_valid   = ($urandom_range(3) != 0);
      bus.s_data    = 1'($urandom_range(1));
      bus.sof       = ($urandom_range(39) == 0);
      bus.out_ready = ($urandom_range(2) == 0);
      tick();
    end
    bus.s_valid = 1'b0; bus.sof = 1'b0; bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
